// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   mdu_op_t    : RV32M funct3 encodings.
//   mdu_state_t : sequencer states.
//   MDU_ITERS   : iterations per multiply/divide (one operand bit per cycle).
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    localparam int unsigned MDU_ITERS = 32;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the core and the multiply/divide unit.
//   start/op/op_a/op_b/rd_in : request, sampled by the unit only when idle.
//   busy                     : unit occupied; core stalls.
//   done/result/rd_out/wb_en : one-cycle completion and register-file write.
// master = core side, slave = unit side.
interface mdu_seq_if #(
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned ADDR_WDTH = 5
);
    logic                 start;
    logic [2:0]           op;
    logic [DATA_WDTH-1:0] op_a;
    logic [DATA_WDTH-1:0] op_b;
    logic [ADDR_WDTH-1:0] rd_in;
    logic                 busy;
    logic                 done;
    logic [DATA_WDTH-1:0] result;
    logic [ADDR_WDTH-1:0] rd_out;
    logic                 wb_en;

    modport master (
        output start, op, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, wb_en
    );

    modport slave (
        input  start, op, op_a, op_b, rd_in,
        output busy, done, result, rd_out, wb_en
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes on acceptance; one 2W-bit shift register
// and one (W+1)-bit adder/subtractor serve both shift-add multiply and
// restoring divide, one bit per cycle. Signs are re-applied in FIX.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset; discards any operation in flight.
//   bus  : mdu_seq_if slave modport (request in, busy/done/result/rd_out/wb_en out).
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned ADDR_WDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    mdu_seq_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MDU_ITERS);
    localparam int unsigned W     = DATA_WDTH;

    mdu_state_t         r_state;
    mdu_op_t            r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_b;
    logic               r_neg;
    logic               r_rem_neg;
    logic               r_special;
    logic [W-1:0]       r_result;
    logic [ADDR_WDTH-1:0] r_rd;
    logic               r_busy;
    logic               r_done;

    mdu_op_t            w_op;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic               w_div0;
    logic               w_ovf;
    logic [W-1:0]       w_spec_res;
    logic [W:0]         w_add_a;
    logic [W:0]         w_add_b;
    logic [W:0]         w_sum;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quo;
    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_fix_res;

    // Request decode: signedness, magnitudes and the early-out cases.
    always_comb begin
        w_op    = mdu_op_t'(bus.op);
        w_a_sgn = bus.op_a[W-1] &
                  (w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM);
        w_b_sgn = bus.op_b[W-1] &
                  (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM);
        // Magnitude of the most negative value wraps back to 2^(W-1), which is
        // exactly right in the unsigned datapath.
        w_a_mag = w_a_sgn ? (~bus.op_a + 1'b1) : bus.op_a;
        w_b_mag = w_b_sgn ? (~bus.op_b + 1'b1) : bus.op_b;
        w_div0  = bus.op[2] && (bus.op_b == '0);
        w_ovf   = (w_op == OP_DIV || w_op == OP_REM) &&
                  (bus.op_a == {1'b1, {(W-1){1'b0}}}) && (bus.op_b == '1);
        if (w_div0)
            w_spec_res = bus.op[1] ? bus.op_a : '1;
        else
            w_spec_res = bus.op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    // Shared adder: multiply adds the multiplicand to the upper half;
    // divide subtracts the divisor from the shifted partial remainder.
    always_comb begin
        if (r_op[2]) begin
            w_add_a = r_acc[2*W-1:W-1];
            w_add_b = ~{1'b0, r_b};
        end else begin
            w_add_a = {1'b0, r_acc[2*W-1:W]};
            w_add_b = {1'b0, r_b};
        end
        w_sum = w_add_a + w_add_b + {{W{1'b0}}, r_op[2]};
    end

    // Sign correction and result selection.
    always_comb begin
        w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
        w_rem  = r_rem_neg ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
        unique case (r_op)
            OP_MUL:                        w_fix_res = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*W-1:W];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo;
            default:                       w_fix_res = w_rem;
        endcase
        if (r_special)
            w_fix_res = r_acc[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
            r_rd      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op      <= w_op;
                        r_rd      <= bus.rd_in;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_b       <= w_b_mag;
                        r_neg     <= w_a_sgn ^ w_b_sgn;
                        r_rem_neg <= w_a_sgn;
                        // Early-out results park in the low accumulator word and
                        // pass through FIX untouched, so done arrives two edges
                        // after acceptance like the normal path's final two steps.
                        if (w_div0 || w_ovf) begin
                            r_special <= 1'b1;
                            r_acc     <= {{W{1'b0}}, w_spec_res};
                            r_state   <= FIX;
                        end else begin
                            r_special <= 1'b0;
                            r_acc     <= {{W{1'b0}}, w_a_mag};
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (r_op[2]) begin
                        // Restoring divide: keep the difference only if non-negative.
                        if (!w_sum[W])
                            r_acc <= {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
                        else
                            r_acc <= {r_acc[2*W-2:0], 1'b0};
                    end else begin
                        // Shift-add multiply, multiplier consumed LSB first from the low half.
                        if (r_acc[0])
                            r_acc <= {w_sum, r_acc[W-1:1]};
                        else
                            r_acc <= {1'b0, r_acc[2*W-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(MDU_ITERS - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd;
    assign bus.wb_en  = r_done && (r_rd != '0);

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes the reference result and
// completion edge for each request; a negedge monitor pops and compares on done.
module tb_mdu_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_seq_if #(.DATA_WDTH(32), .ADDR_WDTH(5)) bus ();

    mdu_seq #(.DATA_WDTH(32), .ADDR_WDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb64, ps;
        logic [63:0]        pu;
        int                 ia, ib;
        sa   = $signed(a);
        sb64 = $signed(b);
        ia   = a;
        ib   = b;
        case (op)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = sa * sb64; return ps[63:32]; end
            3'd2: begin ps = sa * $signed({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (op[2] && b == 0) ||
               ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
                check("wb_en", {31'b0, bus.wb_en}, {31'b0, (e.rd != 0)});
                check("busy_at_done", {31'b0, bus.busy}, 32'd1);
                check("latency", cyc, e.due);
                last_res = e.res;
            end
        end
    end

    // Issue one request; optionally pulse a second start poke_at cycles in.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int unsigned poke_at);
        exp_t        e;
        int unsigned waited;
        @(negedge clk);
        check("result_hold", bus.result, last_res);
        e.res = ref_model(op, a, b);
        e.rd  = rd;
        e.due = cyc + 1 + (is_special(op, a, b) ? 1 : 33);
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.rd_in = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        bus.rd_in = 5'($urandom);
        check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        if (poke_at != 0) begin
            repeat (poke_at - 1) @(negedge clk);
            bus.start = 1'b1;
            bus.op    = 3'($urandom);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        waited = 0;
        while (bus.done !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles (cycle %0d)", cyc);
            sb.delete();
        end
        @(posedge clk);
        #1;
        check("busy_after_done", {31'b0, bus.busy}, 32'd0);
        check("done_pulse_width", {31'b0, bus.done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'b0, bus.busy},   32'd0);
        check("rst_done",   {31'b0, bus.done},   32'd0);
        check("rst_wb_en",  {31'b0, bus.wb_en},  32'd0);
        check("rst_result", bus.result,          32'd0);
        check("rst_rd_out", {27'b0, bus.rd_out}, 32'd0);
        rst = 1'b0;

        // Directed cases.
        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0);
        do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  0);
        do_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  0);
        do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  0);
        do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  0);
        do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  0);
        do_op(3'd5, 32'd100,        32'd7,         5'd7,  0);
        do_op(3'd7, 32'd100,        32'd7,         5'd8,  0);
        do_op(3'd5, 32'h1234,       32'd0,         5'd9,  0);
        do_op(3'd6, 32'h1234,       32'd0,         5'd10, 0);
        do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 0);
        do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 0);
        do_op(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 5'd13, 10);
        do_op(3'd7, 32'd55,         32'd9,         5'd0,  0);

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        bus.rd_in = 5'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",   {31'b0, bus.busy},   32'd0);
        check("midrst_done",   {31'b0, bus.done},   32'd0);
        check("midrst_result", bus.result,          32'd0);
        check("midrst_rd_out", {27'b0, bus.rd_out}, 32'd0);
        check("midrst_wb_en",  {31'b0, bus.wb_en},  32'd0);
        last_res = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_op(3'd4, 32'hFFFF_FC18, 32'd3, 5'd18, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            do_op(3'($urandom), pick(), pick(), rd, 0);
        end

        repeat (5) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
